ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Round-robin arbiter that shares one port of a `simple_ram_dual_clock` instance between `NREQ` requesters, one single-beat access per cycle. Each requester may hold a `lock` to take up to `MAX_BURST` consecutive cycles before it is forced to yield. The block drives the RAM address, write-data and write-enable signals combinationally from the granted requester. It registers read data and returns it with a per-requester valid strobe. It sits between the FIFO-drain and DMA-style clients and the shared frame RAM.

## Interface
- `NREQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 32: RAM data width.
- `ADDR_WIDTH`, 8: RAM address width.
- `MAX_BURST`, 4: maximum consecutive grants to a locked requester, ≥1.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  `NREQ`  per-requester access request.
- `lock`  in  `NREQ`  per-requester burst-hold request; only meaningful together with `req`.
- `we`  in  `NREQ`  1 = write, 0 = read.
- `addr`  in  `NREQ*ADDR_WIDTH`  packed; requester i occupies `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `wdata`  in  `NREQ*DATA_WIDTH`  packed, same layout as `addr`.
- `gnt`  out  `NREQ`  one-hot (or zero) combinational grant; an access completes on a cycle where `req[i] & gnt[i]`.
- `rvalid`  out  `NREQ`  registered one-cycle strobe; high the cycle after a granted read.
- `rdata`  out  `DATA_WIDTH`  registered read data; valid when any `rvalid` bit is high.
- `ram_addr`  out  `ADDR_WIDTH`  to the RAM read/write address.
- `ram_wdata`  out  `DATA_WIDTH`  to the RAM write data.
- `ram_we`  out  1  to the RAM write enable.
- `ram_rdata`  in  `DATA_WIDTH`  combinational RAM read data.

## Operation
- **State registers**
  - `ptr`: round-robin start index, `$clog2(NREQ)` bits.
  - `owner`: index of the last grant.
  - `owner_v`: 1 if the previous cycle issued a grant.
  - `cnt`: consecutive-grant count, `$clog2(MAX_BURST+1)` bits.
- **Hold condition:** `hold = owner_v & req[owner] & lock[owner] & (cnt < MAX_BURST)`. When `hold` is true, grant `owner`.
- **Normal arbitration:** otherwise, grant the first asserted `req` searching `ptr`, `ptr+1`, … mod `NREQ`.
- **Burst expiry:** if `owner_v & lock[owner] & cnt == MAX_BURST`, the search starts at `owner+1`. `owner` is considered last, so it gets the grant only if it is the sole requester.
- **On a cycle with grant g:**
  - `ptr <= (g+1) mod NREQ`, `owner <= g`, `owner_v <= 1`.
  - `cnt <= (owner_v && g == owner && cnt < MAX_BURST) ? cnt+1 : 1`.
- **On a cycle with no grant:** `owner_v <= 0`, `cnt <= 0`; `ptr` is unchanged.
- **RAM drive on a grant g:**
  - `ram_addr` = `addr[g]`.
  - `ram_wdata` = `wdata[g]`.
  - `ram_we` = `we[g]`.
- **RAM drive with no grant:** `ram_addr`, `ram_wdata` and `ram_we` are all 0.
- **Read return:** on a granted read (`we[g] = 0`), `rdata <= ram_rdata` and `rvalid <= 1<<g`. On any other cycle `rvalid <= 0` and `rdata` holds.
- **Lock without request:** `lock` with `req` low has no effect; a burst ends as soon as `req[owner]` drops.

## Timing
- **Reset:** while `resetn` is low, `gnt = 0` and `ram_we = 0`. Registers clear asynchronously: `ptr = 0`, `owner = 0`, `owner_v = 0`, `cnt = 0`, `rvalid = 0`, `rdata = 0`.
- **Reset mid-burst:** abandons the burst. After release, arbitration restarts from requester 0 with no hold.
- **Grant latency:** `gnt` is valid in the same cycle `req` rises (0-cycle).
- **Write:** takes effect at the edge that ends the granted cycle.
- **Read latency:** 1 cycle. `rdata`/`rvalid` appear the cycle after the grant.
- **Write then read:** a write to A in cycle n followed by a read of A in cycle n+1 returns the new data in cycle n+2.
- **Throughput:** one access per cycle, with no bubble when ownership switches.
- **Fairness:** no requester waits more than `(NREQ-1)*MAX_BURST` cycles while `req` is held.
- **Request stability:** a requester must hold `req`/`we`/`addr`/`wdata` stable until the cycle it sees `gnt`. Deasserting `req` before a grant withdraws the request with no side effect.

## Test plan
- **Reset values:** assert `resetn` low with all `req` high → `gnt = 0`, `ram_we = 0`, `rvalid = 0`. Release → first `gnt = 4'b0001`.
- **Round-robin, `NREQ=4`:** `req = 4'b1111`, `lock = 0` for 8 cycles → `gnt` sequence 0001, 0010, 0100, 1000, 0001, ….
- **Burst limit, `MAX_BURST=4`:** `req = 4'b0011`, `lock[0] = 1` → `gnt[0]` for 4 cycles, then `gnt[1]` for 1 cycle, then `gnt[0]` for 4 cycles.
- **Write/read:** req1 writes `0xDEADBEEF` to address `0x10`; next cycle req2 reads `0x10` → the following cycle `rvalid = 4'b0100`, `rdata = 0xDEADBEEF`.
- **Sole locked requester:** `req = 4'b0100`, `lock[2] = 1` for 10 cycles → `gnt[2]` continuously, `cnt` running 1,2,3,4,1,2,….
- **Reset mid-burst:** pulse `resetn` low during the 3rd beat of a req3 locked burst, with `req = 4'b1001` → after release, `gnt = 4'b0001` first.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between NREQ requesters, with
// bounded lock bursts and a registered read-return path.
module ram_port_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            lock,
  input  logic [NREQ-1:0]            we,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_wdata,
  output logic                       ram_we,
  input  logic [DATA_WIDTH-1:0]      ram_rdata
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  logic [PW-1:0] ptr, owner, start, gidx;
  logic [CW-1:0] cnt;
  logic          owner_v, hold, expire, gvalid;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
    return PW'((int'(a) + b) % NREQ);
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    hold   = owner_v & req[owner] & lock[owner] & (cnt < CNT_MAX);
    expire = owner_v & lock[owner] & (cnt == CNT_MAX);
    // An expired burst restarts the search just past the owner, so the
    // owner is visited last and only wins when nobody else is asking.
    start  = expire ? wrap_add(owner, 1) : ptr;
    gvalid = 1'b0;
    gidx   = '0;
    if (resetn) begin
      if (hold) begin
        gvalid = 1'b1;
        gidx   = owner;
      end else begin
        // Walk backwards so the nearest requester after start wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
          if (req[wrap_add(start, k)]) begin
            gvalid = 1'b1;
            gidx   = wrap_add(start, k);
          end
        end
      end
    end
  end

  always_comb begin
    gnt       = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gvalid && gidx == PW'(i)) begin
        gnt[i]    = 1'b1;
        ram_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        ram_we    = we[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr     <= '0;
      owner   <= '0;
      owner_v <= 1'b0;
      cnt     <= '0;
      rvalid  <= '0;
      rdata   <= '0;
    end else begin
      if (gvalid) begin
        ptr     <= wrap_add(gidx, 1);
        owner   <= gidx;
        owner_v <= 1'b1;
        cnt     <= (owner_v && gidx == owner && cnt < CNT_MAX) ? cnt + CW'(1) : CW'(1);
      end else begin
        owner_v <= 1'b0;
        cnt     <= '0;
      end
      if (gvalid && !ram_we) begin
        rvalid <= gnt;
        rdata  <= ram_rdata;
      end else begin
        rvalid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random
// traffic against a behavioural arbiter/RAM model.
module tb_ram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic [N-1:0]    req, lock, we, gnt, rvalid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, ram_wdata, ram_rdata;
  logic [AW-1:0]   ram_addr;
  logic            ram_we;

  int checks = 0;
  int errors = 0;

  // Attached RAM: combinational read, write at the edge ending the cycle.
  logic [DW-1:0] ram_mem [256];
  assign ram_rdata = ram_mem[ram_addr];
  always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_wdata;

  // Reference model state
  int           m_ptr, m_owner, m_cnt;
  bit           m_ov;
  logic [N-1:0] m_rvalid;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] model_mem [256];

  ram_port_arbiter #(.NREQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .resetn(resetn), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_ov = 0;
    m_rvalid = '0; m_rdata = '0;
  endtask

  function automatic int model_grant();
    int start;
    if (!resetn) return -1;
    if (m_ov && req[m_owner] && lock[m_owner] && m_cnt < MB) return m_owner;
    start = (m_ov && lock[m_owner] && m_cnt == MB) ? (m_owner + 1) % N : m_ptr;
    for (int k = 0; k < N; k++)
      if (req[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_step(input int g);
    int a;
    if (g >= 0) begin
      m_cnt   = (m_ov && g == m_owner && m_cnt < MB) ? m_cnt + 1 : 1;
      m_ptr   = (g + 1) % N;
      m_owner = g;
      m_ov    = 1;
      a = int'(addr[g*AW +: AW]);
      if (we[g]) begin
        model_mem[a] = wdata[g*DW +: DW];
        m_rvalid = '0;
      end else begin
        m_rvalid = N'(1 << g);
        m_rdata  = model_mem[a];
      end
    end else begin
      m_ov = 0; m_cnt = 0; m_rvalid = '0;
    end
  endtask

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  // One clock cycle, entered just after a falling edge with inputs applied.
  // want >= 0 adds a directed check of gnt against a fixed pattern.
  task automatic cycle(input string tag, input int want);
    int g;
    #1;
    g = model_grant();
    chk({tag, ":gnt"}, gnt, (g >= 0) ? (64'd1 << g) : 64'd0);
    if (want >= 0) chk({tag, ":gnt_dir"}, gnt, 64'(want));
    chk({tag, ":ram_we"}, ram_we, (g >= 0) ? 64'(we[g]) : 64'd0);
    chk({tag, ":ram_addr"}, ram_addr, (g >= 0) ? 64'(addr[g*AW +: AW]) : 64'd0);
    chk({tag, ":ram_wdata"}, ram_wdata, (g >= 0) ? 64'(wdata[g*DW +: DW]) : 64'd0);
    @(posedge clk);
    if (resetn) model_step(g);
    @(negedge clk);
    chk({tag, ":rvalid"}, rvalid, m_rvalid);
    chk({tag, ":rdata"}, rdata, m_rdata);
  endtask

  initial begin
    req = '1; lock = '0; we = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = $urandom;
      model_mem[i] = ram_mem[i];
    end
    model_reset();
    #1 resetn = 1'b0;
    @(negedge clk);

    // Reset holds everything off even with all requests up
    repeat (2) cycle("reset", 0);

    // Plain round robin after release
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) cycle("rr", 1 << (i % 4));

    // Burst limit: 4 locked beats to req0, one to req1, then 4 again
    req = 4'b0011; lock = 4'b0001;
    begin
      int exp_seq [9] = '{1, 1, 1, 1, 2, 1, 1, 1, 1};
      for (int i = 0; i < 9; i++) cycle("burst", exp_seq[i]);
    end

    // Write then read of the same address, back to back
    req = '0; lock = '0;
    cycle("idle", 0);
    req = 4'b0010; we = 4'b0010;
    set_req(1, 1'b1, 8'h10, 32'hDEADBEEF);
    cycle("write", 4'b0010);
    req = 4'b0100; we = '0;
    set_req(2, 1'b0, 8'h10, 32'h0);
    cycle("read", 4'b0100);
    chk("wr_rd:rvalid", rvalid, 64'h4);
    chk("wr_rd:rdata", rdata, 64'hDEADBEEF);

    // Sole locked requester keeps the grant, counter wraps 1..4
    req = '0;
    cycle("idle", 0);
    req = 4'b0100; lock = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      cycle("sole", 4'b0100);
      chk("sole:cnt", 64'(dut.cnt), 64'((i % 4) + 1));
    end

    // Reset during the third beat of a req3 burst
    req = '0; lock = '0;
    cycle("idle", 0);
    req = 4'b1001; lock = 4'b1000;
    cycle("mid1", 4'b1000);
    cycle("mid2", 4'b1000);
    #1 chk("mid3:gnt", gnt, 64'h8);
    #1 resetn = 1'b0;
    model_reset();
    #1;
    chk("mid_rst:gnt", gnt, 64'h0);
    chk("mid_rst:ram_we", ram_we, 64'h0);
    chk("mid_rst:rvalid", rvalid, 64'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cycle("post_rst", 4'b0001);

    // Random traffic over a small address window, with rare reset pulses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        resetn = 1'b0;
        model_reset();
      end else begin
        resetn = 1'b1;
      end
      req  = N'($urandom);
      lock = ($urandom_range(3) == 0) ? '0 : N'($urandom);
      for (int j = 0; j < N; j++)
        set_req(j, 1'($urandom), AW'($urandom_range(7)), $urandom);
      cycle("rand", -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
